mul_acc: RTL and testbench
==========================

Name: mul_acc

Overview:
- Downstream consumer of the 4x4 pipelined multiplier.
- Takes the 8-bit product stream with a valid qualifier and sums LEN consecutive products into one dot-product result.
- Presents the result on a valid/ready output register.
- The qualifier is aligned to the multiplier's fixed latency by the integrating level.

Parameters:
DATA_W, 8, product width (matches multiplier mul_out)
LEN, 4, products per group; legal range 1..16
ACC_W, 12, accumulator/result width; DATA_W+clog2(LEN) needed for lossless sum

Ports:
clk  input  1  rising-edge clock
rst  input  1  reset, synchronous, active-high
acc_clr  input  1  synchronous clear of partial group
in_data  input  DATA_W  product from multiplier (unsigned)
in_valid  input  1  in_data qualifier
in_ready  output  1  beat accepted when in_valid && in_ready
out_data  output  ACC_W  group sum
out_valid  output  1  out_data qualifier
out_ready  input  1  downstream accepts when out_valid && out_ready

Behaviour:
- Reset (rst=1 at posedge): out_valid=0, out_data=0, cnt=0, acc=0. in_ready is low while rst=1 and high on the first cycle after.
- Reset mid-group or mid-hold: partial sum and pending result are dropped, with no output beat.
- in_ready = !acc_clr && (!out_valid || out_ready). This is a one-entry output register with pass-through on pop.
- Accepted beat with cnt==0: acc <= in_data (zero-extended), cnt <= 1.
- Accepted beat with 0<cnt<LEN-1: acc <= acc + in_data, cnt <= cnt+1.
- Accepted beat with cnt==LEN-1 (last beat):
  - out_data <= acc + in_data, out_valid <= 1, cnt <= 0.
  - acc value after this beat is don't-care; the next group loads it.
- Latency: out_valid rises 1 cycle after the last beat is accepted.
- LEN=1: every accepted beat produces a result; sum = in_data.
- Output pop (out_valid && out_ready) without a same-cycle last beat: out_valid <= 0; out_data holds its last value.
- Pop and last beat in the same cycle: new result loads and out_valid stays 1. This gives back-to-back groups at full rate.
- Stall: out_valid && !out_ready forces in_ready=0; the partial group holds (cnt, acc unchanged).
- acc_clr=1: cnt <= 0, acc <= 0, in_ready=0 (the beat is not accepted and upstream must hold or drop it). A pending out_valid/out_data is unaffected.
- acc_clr and out pop in the same cycle: both take effect.
- Arithmetic: unsigned. Without the optional feature, the sum is modulo 2^ACC_W.
- States are encoded by cnt: IDLE (cnt==0), ACCUM (cnt>0). out_valid is an independent flag.

Optional Feature:
- Macro: MUL_ACC_SAT_EN.
- Defined: each add saturates at 2^ACC_W-1. Once saturated, the result stays saturated for the rest of the group.
- Undefined: the add wraps.
- The feature is only observable when ACC_W < DATA_W+clog2(LEN).

Decomposition:
- Package mul_acc_pkg:
  - DATA_W and LEN defaults.
  - CNT_W = clog2(LEN) (min 1).
  - Function acc_add(a, b) returning the wrap or saturating sum under the macro.
- Sub-module mul_acc_add: combinational ACC_W adder with the saturate option. Instantiated once.
- The rest is flat.

Test Plan:
- Basic: LEN=4, rst held 10 cycles then released; 4 beats of 0x64 (0xa*0xa), out_ready=1 -> out_data=0x190 one cycle after the 4th beat; out_valid high 1 cycle.
- Back-to-back: LEN=4, 8 consecutive beats (4x0x64, then 4x0x68 from 0xd*0x8), out_ready=1 -> results 0x190 then 0x1A0. in_ready stays 1 throughout; no bubble.
- Backpressure: out_ready=0 after the first result -> in_ready=0 and out_data holds 0x190. Raise out_ready -> pop, and the next beat is accepted the same cycle.
- Clear and reset mid-group: two beats 0x64, acc_clr pulse, then 4 beats 0x01 -> result 0x004. Repeat with rst pulse instead -> no result emitted and out_valid=0.
- LEN=1 boundary: beats 0xFF, 0x00 -> out_data 0x0FF, then 0x000 on consecutive cycles.
- Saturation: ACC_W=8, LEN=4, 4 beats 0x64 -> 0xFF with MUL_ACC_SAT_EN defined, 0x90 without.

Source files
------------

// File: rtl/mul_acc_pkg.sv
// mul_acc_pkg: shared defaults and the group-sum add; MUL_ACC_SAT_EN selects saturating adds
package mul_acc_pkg;
   localparam int DATA_W = 8;
   localparam int LEN = 4;
   localparam int CNT_W = LEN > 1 ? $clog2(LEN) : 1;
   function automatic logic [31:0] acc_add(input logic [31:0] a, input logic [31:0] b, input int unsigned w);
      logic [32:0] s;
      logic [31:0] m;
      s = {1'b0, a} + {1'b0, b};
      m = 32'((33'd1 << w) - 33'd1);
`ifdef MUL_ACC_SAT_EN
      return s > {1'b0, m} ? m : s[31:0];
`else
      return s[31:0] & m;
`endif
   endfunction
endpackage

// File: rtl/mul_acc_add.sv
// mul_acc_add: W-bit accumulator adder, wrapping or saturating under MUL_ACC_SAT_EN
module mul_acc_add
   import mul_acc_pkg::*;
#(
   parameter int W = 12
) (
   input  logic [W-1:0] a_i,
   input  logic [W-1:0] b_i,
   output logic [W-1:0] s_o
);
   logic [31:0] s;
   assign s = acc_add(32'(a_i), 32'(b_i), W);
   assign s_o = s[W-1:0];
endmodule

// File: rtl/mul_acc.sv
// mul_acc: sums LEN accepted products into one result on a valid/ready output register; MUL_ACC_SAT_EN saturates
module mul_acc
   import mul_acc_pkg::*;
#(
   parameter int DATA_W = mul_acc_pkg::DATA_W,
   parameter int LEN = mul_acc_pkg::LEN,
   parameter int ACC_W = 12
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              acc_clr,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_valid,
   output logic              in_ready,
   output logic [ACC_W-1:0]  out_data,
   output logic              out_valid,
   input  logic              out_ready
);
   localparam int CW = LEN > 1 ? $clog2(LEN) : 1;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [ACC_W-1:0] acc_q, acc_d, out_data_q, out_data_d, sum;
   logic out_valid_q, out_valid_d, accept, last;
   // first beat of a group adds onto zero so the stale accumulator never leaks in
   mul_acc_add #(.W(ACC_W)) u_add (
      .a_i(cnt_q == '0 ? '0 : acc_q),
      .b_i(ACC_W'(in_data)),
      .s_o(sum)
   );
   assign in_ready = !rst && !acc_clr && (!out_valid_q || out_ready);
   assign accept = in_valid && in_ready;
   assign last = cnt_q == CW'(LEN - 1);
   assign out_data = out_data_q;
   assign out_valid = out_valid_q;
   always_comb begin
      cnt_d = acc_clr ? '0 : accept ? (last ? '0 : cnt_q + 1'b1) : cnt_q;
      acc_d = acc_clr ? '0 : accept ? sum : acc_q;
      out_valid_d = (accept && last) || (out_valid_q && !out_ready);
      out_data_d = accept && last ? sum : out_data_q;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
         acc_q <= '0;
         out_valid_q <= 1'b0;
         out_data_q <= '0;
      end else begin
         cnt_q <= cnt_d;
         acc_q <= acc_d;
         out_valid_q <= out_valid_d;
         out_data_q <= out_data_d;
      end
   end
endmodule

// File: tb/tb_mul_acc.sv
// tb_mul_acc: randomized and directed checks of mul_acc against a group-list reference model
module tb_mul_acc;
   localparam int LEN = 4;
   localparam int ACC_W = 12;
   logic clk = 1'b0;
   logic rst, acc_clr, in_valid, out_ready;
   logic [7:0] in_data;
   logic in_ready, out_valid, rdy1, ov1, rdy8, ov8;
   logic [ACC_W-1:0] out_data;
   logic [7:0] od1, od8;
   int n_chk = 0;
   int n_pass = 0;
   int part[$];
   logic mov = 1'b0;
   logic [ACC_W-1:0] mod = '0;
   always #5 clk = ~clk;
   mul_acc #(.DATA_W(8), .LEN(LEN), .ACC_W(ACC_W)) dut (
      .clk(clk), .rst(rst), .acc_clr(acc_clr), .in_data(in_data), .in_valid(in_valid),
      .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready)
   );
   mul_acc #(.DATA_W(8), .LEN(1), .ACC_W(8)) u_len1 (
      .clk(clk), .rst(rst), .acc_clr(acc_clr), .in_data(in_data), .in_valid(in_valid),
      .in_ready(rdy1), .out_data(od1), .out_valid(ov1), .out_ready(out_ready)
   );
   mul_acc #(.DATA_W(8), .LEN(4), .ACC_W(8)) u_acc8 (
      .clk(clk), .rst(rst), .acc_clr(acc_clr), .in_data(in_data), .in_valid(in_valid),
      .in_ready(rdy8), .out_data(od8), .out_valid(ov8), .out_ready(out_ready)
   );
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      else n_pass++;
   endtask
   function automatic logic [ACC_W-1:0] group_sum();
      int s = 0;
      foreach (part[i]) s += part[i];
`ifdef MUL_ACC_SAT_EN
      return s > (1 << ACC_W) - 1 ? ACC_W'((1 << ACC_W) - 1) : ACC_W'(s);
`else
      return ACC_W'(s);
`endif
   endfunction
   task automatic cyc(input logic r, input logic c, input logic v, input logic [7:0] d, input logic ordy);
      logic er, acc;
      rst = r; acc_clr = c; in_valid = v; in_data = d; out_ready = ordy;
      er = !r && !c && (!mov || ordy);
      acc = v && er;
      #4;
      check("in_ready", in_ready, er);
      @(posedge clk);
      if (r) begin
         part.delete();
         mov = 1'b0;
         mod = '0;
      end else begin
         if (mov && ordy) mov = 1'b0;
         if (c) part.delete();
         if (acc) begin
            part.push_back(d);
            if (part.size() == LEN) begin
               mod = group_sum();
               mov = 1'b1;
               part.delete();
            end
         end
      end
      #1;
      check("out_valid", out_valid, mov);
      check("out_data", out_data, mod);
   endtask
   initial begin
      repeat (10) cyc(1, 0, 0, 8'h00, 1);
      check("rst_out_valid", out_valid, 0);
      check("rst_out_data", out_data, 0);
      repeat (4) cyc(0, 0, 1, 8'h64, 1);
      check("basic_sum", out_data, 12'h190);
      check("basic_valid", out_valid, 1);
`ifdef MUL_ACC_SAT_EN
      check("acc8_sat", od8, 8'hFF);
`else
      check("acc8_wrap", od8, 8'h90);
`endif
      cyc(0, 0, 0, 8'h00, 1);
      check("basic_drop", out_valid, 0);
      repeat (4) cyc(0, 0, 1, 8'h64, 1);
      check("b2b_first", out_data, 12'h190);
      repeat (4) cyc(0, 0, 1, 8'h68, 1);
      check("b2b_second", out_data, 12'h1A0);
      check("b2b_valid", out_valid, 1);
      repeat (4) cyc(0, 0, 1, 8'h64, 1);
      repeat (3) cyc(0, 0, 1, 8'h11, 0);
      check("stall_hold", out_data, 12'h190);
      cyc(0, 0, 1, 8'h11, 1);
      check("stall_pop", out_valid, 0);
      cyc(0, 0, 0, 8'h00, 1);
      cyc(0, 1, 0, 8'h00, 1);
      repeat (2) cyc(0, 0, 1, 8'h64, 1);
      cyc(0, 1, 1, 8'h64, 1);
      repeat (4) cyc(0, 0, 1, 8'h01, 1);
      check("clr_sum", out_data, 12'h004);
      repeat (2) cyc(0, 0, 1, 8'h64, 1);
      cyc(1, 0, 1, 8'h64, 1);
      repeat (2) cyc(0, 0, 1, 8'h64, 1);
      check("rst_mid_valid", out_valid, 0);
      cyc(1, 0, 0, 8'h00, 1);
      cyc(0, 0, 1, 8'hFF, 1);
      check("len1_ff", od1, 8'hFF);
      check("len1_valid", ov1, 1);
      cyc(0, 0, 1, 8'h00, 1);
      check("len1_00", od1, 8'h00);
      for (int i = 0; i < 600; i++)
         cyc($urandom_range(0, 59) == 0, $urandom_range(0, 19) == 0, $urandom_range(0, 3) != 0,
             8'($urandom), $urandom_range(0, 9) < 7);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
